// File: rtl/bch_chien_search_if.sv
// Request/result bundle between the Chien-search stage and its neighbours.
// master drives the request side; slave is the search engine.
interface bch_chien_search_if;
   logic        start;
   logic [1:0]  code;
   logic [2:0]  deg;
   logic [10:0] lambda0;
   logic [10:0] lambda1;
   logic [10:0] lambda2;
   logic [10:0] lambda3;
   logic [10:0] lambda4;
   logic        busy;
   logic        out_valid;
   logic [9:0]  out_pos;
   logic        done;
   logic        fail;
   logic [2:0]  err_cnt;

   modport master (
      output start, code, deg, lambda0, lambda1, lambda2, lambda3, lambda4,
      input  busy, out_valid, out_pos, done, fail, err_cnt
   );

   modport slave (
      input  start, code, deg, lambda0, lambda1, lambda2, lambda3, lambda4,
      output busy, out_valid, out_pos, done, fail, err_cnt
   );
endinterface

// File: rtl/bch_chien_search.sv
// BCH Chien search: evaluates Lambda(alpha^-i) for i=0..n-1, one position per cycle,
// streaming roots as error positions and flagging a root-count/degree mismatch.
module bch_chien_search #(
   parameter bit EARLY_STOP = 1'b1
) (
   input logic               clk,
   input logic               rstn,
   bch_chien_search_if.slave bus
);
   typedef enum logic [1:0] {IDLE = 2'd0, EVAL = 2'd1, DONE = 2'd2} state_t;

   function automatic logic [9:0] field_mask(input logic [1:0] c);
      case (c)
         2'd1:    return 10'h03F;
         2'd2:    return 10'h0FF;
         default: return 10'h3FF;
      endcase
   endfunction

   function automatic logic [9:0] last_idx(input logic [1:0] c);
      case (c)
         2'd1:    return 10'd62;
         2'd2:    return 10'd254;
         default: return 10'd1022;
      endcase
   endfunction

   // Divide by alpha: an odd value first absorbs the field polynomial so the shift is exact.
   function automatic logic [9:0] div_alpha(input logic [9:0] x, input logic [1:0] c);
      logic [9:0] r;
      r = {1'b0, x[9:1]};
      if (x[0]) begin
         case (c)
            2'd1:    r = r ^ 10'h021;
            2'd2:    r = r ^ 10'h08E;
            default: r = r ^ 10'h204;
         endcase
      end
      return r;
   endfunction

   function automatic logic [9:0] mul_alpha_inv_pow(input logic [9:0] x, input int unsigned k,
                                                    input logic [1:0] c);
      logic [9:0] r;
      r = x;
      for (int unsigned j = 0; j < k; j++) r = div_alpha(r, c);
      return r;
   endfunction

   state_t          state_q, state_d;
   logic [1:0]      code_q, code_d, code_in;
   logic [2:0]      deg_q, deg_d;
   logic [2:0]      cnt_q, cnt_d, cnt_inc, cnt_new;
   logic [2:0]      err_cnt_q, err_cnt_d;
   logic [4:0][9:0] term_q, term_d, lam_in;
   logic [9:0]      idx_q, idx_d;
   logic [9:0]      out_pos_q, out_pos_d;
   logic [9:0]      sum;
   logic            out_valid_q, out_valid_d;
   logic            fail_q, fail_d;
   logic            root;

   assign code_in = (bus.code == 2'd0) ? 2'd3 : bus.code;

   always_comb begin
      lam_in    = '0;
      lam_in[0] = 10'(bus.lambda0 & 11'(field_mask(code_in)));
      lam_in[1] = 10'(bus.lambda1 & 11'(field_mask(code_in)));
      lam_in[2] = 10'(bus.lambda2 & 11'(field_mask(code_in)));
      lam_in[3] = 10'(bus.lambda3 & 11'(field_mask(code_in)));
      lam_in[4] = 10'(bus.lambda4 & 11'(field_mask(code_in)));
   end

   always_comb begin
      state_d     = state_q;
      code_d      = code_q;
      deg_d       = deg_q;
      cnt_d       = cnt_q;
      err_cnt_d   = err_cnt_q;
      term_d      = term_q;
      idx_d       = idx_q;
      out_pos_d   = out_pos_q;
      out_valid_d = 1'b0;
      fail_d      = fail_q;
      sum         = '0;
      for (int unsigned k = 0; k < 5; k++) sum = sum ^ term_q[k];
      root    = (sum == '0);
      cnt_inc = (cnt_q == 3'd7) ? cnt_q : cnt_q + 3'd1;
      cnt_new = root ? cnt_inc : cnt_q;

      case (state_q)
         IDLE: begin
            if (bus.start) begin
               code_d    = code_in;
               deg_d     = bus.deg;
               fail_d    = 1'b0;
               err_cnt_d = '0;
               term_d    = lam_in;
               idx_d     = '0;
               cnt_d     = '0;
               if (bus.deg == 3'd0) begin
                  state_d = DONE;
               end else if (bus.deg > ((code_in == 2'd3) ? 3'd4 : 3'd2) || lam_in[0] == '0) begin
                  state_d = DONE;
                  fail_d  = 1'b1;
               end else begin
                  state_d = EVAL;
               end
            end
         end
         EVAL: begin
            cnt_d = cnt_new;
            // Roots past the fourth are counted but never streamed.
            if (root && cnt_new <= 3'd4) begin
               out_valid_d = 1'b1;
               out_pos_d   = idx_q;
            end
            for (int unsigned k = 0; k < 5; k++) term_d[k] = mul_alpha_inv_pow(term_q[k], k, code_q);
            idx_d = idx_q + 10'd1;
            if (idx_q == last_idx(code_q) || (EARLY_STOP && root && cnt_new == deg_q)) begin
               state_d   = DONE;
               fail_d    = (cnt_new != deg_q);
               err_cnt_d = cnt_new;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q     <= IDLE;
         code_q      <= 2'd3;
         deg_q       <= '0;
         cnt_q       <= '0;
         err_cnt_q   <= '0;
         term_q      <= '0;
         idx_q       <= '0;
         out_pos_q   <= '0;
         out_valid_q <= 1'b0;
         fail_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         code_q      <= code_d;
         deg_q       <= deg_d;
         cnt_q       <= cnt_d;
         err_cnt_q   <= err_cnt_d;
         term_q      <= term_d;
         idx_q       <= idx_d;
         out_pos_q   <= out_pos_d;
         out_valid_q <= out_valid_d;
         fail_q      <= fail_d;
      end
   end

   assign bus.busy      = (state_q != IDLE);
   assign bus.done      = (state_q == DONE);
   assign bus.out_valid = out_valid_q;
   assign bus.out_pos   = out_pos_q;
   assign bus.fail      = fail_q;
   assign bus.err_cnt   = err_cnt_q;
endmodule

// File: tb/tb_bch_chien_search.sv
// Self-checking bench for bch_chien_search against a polynomial-evaluation model
// built from generic GF(2^m) multiplication.
module tb_bch_chien_search;
   logic clk = 1'b0;
   logic rstn = 1'b0;
   always #5 clk = ~clk;

   bch_chien_search_if bus ();

   bch_chien_search #(.EARLY_STOP(1'b1)) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus)
   );

   int errors = 0;
   int checks = 0;

   int unsigned exp_pos[$], exp_off[$];
   int unsigned exp_done, exp_fail, exp_cnt;
   int unsigned obs_pos[$], obs_off[$];
   int unsigned obs_done, obs_fail, obs_cnt;
   bit          obs_timeout;

   function automatic int unsigned eff(input int unsigned c);
      return (c == 0) ? 3 : c;
   endfunction
   function automatic int unsigned f_m(input int unsigned c);
      return (c == 1) ? 6 : (c == 2) ? 8 : 10;
   endfunction
   function automatic int unsigned f_poly(input int unsigned c);
      return (c == 1) ? 'h43 : (c == 2) ? 'h11D : 'h409;
   endfunction
   function automatic int unsigned f_n(input int unsigned c);
      return (1 << f_m(c)) - 1;
   endfunction
   function automatic int unsigned f_t(input int unsigned c);
      return (c == 3) ? 4 : 2;
   endfunction

   function automatic int unsigned gf_mul(input int unsigned a, input int unsigned b, input int unsigned c);
      int unsigned m = f_m(c);
      int unsigned p = f_poly(c);
      int unsigned r = 0;
      int unsigned aa = a;
      for (int unsigned i = 0; i < m; i++) begin
         if (((b >> i) & 1) != 0) r = r ^ aa;
         aa = aa << 1;
         if (((aa >> m) & 1) != 0) aa = aa ^ p;
      end
      return r;
   endfunction

   function automatic int unsigned gf_pow(input int unsigned e, input int unsigned c);
      int unsigned r = 1;
      for (int unsigned i = 0; i < e; i++) r = gf_mul(r, 2, c);
      return r;
   endfunction

   // Expected stream/result for one request (EARLY_STOP=1 instance).
   function automatic void model(input int unsigned code, input int unsigned d,
                                 input int unsigned l0, input int unsigned l1, input int unsigned l2,
                                 input int unsigned l3, input int unsigned l4);
      int unsigned c = eff(code);
      int unsigned mask = f_n(c);
      int unsigned l[5];
      int unsigned x, ainv, v, cnt, last;
      bit stop;
      l[0] = l0 & mask; l[1] = l1 & mask; l[2] = l2 & mask; l[3] = l3 & mask; l[4] = l4 & mask;
      exp_pos.delete(); exp_off.delete();
      exp_fail = 0; exp_cnt = 0; exp_done = 1;
      if (d == 0) return;
      if (d > f_t(c) || l[0] == 0) begin
         exp_fail = 1;
         return;
      end
      ainv = gf_pow(f_n(c) - 1, c);
      x = 1; cnt = 0; last = f_n(c) - 1; stop = 0;
      for (int unsigned i = 0; i < f_n(c) && !stop; i++) begin
         v = 0;
         for (int k = 4; k >= 0; k--) v = gf_mul(v, x, c) ^ l[k];
         if (v == 0) begin
            cnt++;
            if (cnt <= 4) begin
               exp_pos.push_back(i);
               exp_off.push_back(i + 2);
            end
            if (cnt == d) begin
               last = i;
               stop = 1;
            end
         end
         x = gf_mul(x, ainv, c);
      end
      exp_done = last + 2;
      exp_fail = (cnt != d) ? 1 : 0;
      exp_cnt  = (cnt > 7) ? 7 : cnt;
   endfunction

   // Drives one start and records outputs; cycle offsets are relative to the start cycle T.
   task automatic run_search(input int unsigned c, input int unsigned d,
                             input int unsigned l0, input int unsigned l1, input int unsigned l2,
                             input int unsigned l3, input int unsigned l4, input int unsigned inject_at);
      int unsigned k;
      @(negedge clk);
      bus.code = 2'(c); bus.deg = 3'(d);
      bus.lambda0 = 11'(l0); bus.lambda1 = 11'(l1); bus.lambda2 = 11'(l2);
      bus.lambda3 = 11'(l3); bus.lambda4 = 11'(l4);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      obs_pos.delete(); obs_off.delete();
      obs_timeout = 1; obs_done = 0; obs_fail = 0; obs_cnt = 0;
      k = 1;
      while (k <= 1100) begin
         if (k == inject_at) begin
            bus.code = 2'd1; bus.deg = 3'd0; bus.lambda0 = 11'd1;
            bus.start = 1'b1;
         end else begin
            bus.start = 1'b0;
         end
         if (bus.out_valid === 1'b1) begin
            obs_pos.push_back(int'(bus.out_pos));
            obs_off.push_back(k);
         end
         if (bus.done === 1'b1) begin
            obs_done = k; obs_fail = int'(bus.fail); obs_cnt = int'(bus.err_cnt);
            obs_timeout = 0;
            break;
         end
         @(negedge clk);
         k++;
      end
      bus.start = 1'b0;
   endtask

   task automatic test_reset();
      checks++;
      if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0 || bus.out_pos !== 10'd0 ||
          bus.done !== 1'b0 || bus.fail !== 1'b0 || bus.err_cnt !== 3'd0) begin
         errors++;
         $display("FAIL reset_state: busy=%b ov=%b pos=%0d done=%b fail=%b cnt=%0d, required all 0",
                  bus.busy, bus.out_valid, bus.out_pos, bus.done, bus.fail, bus.err_cnt);
      end
   endtask

   task automatic test_vectors();
      int unsigned tv[8][7] = '{
         '{1, 1, 1, 'h020, 0, 0, 0},
         '{2, 2, 1, 'h08F, 'h08E, 0, 0},
         '{3, 0, 1, 5, 7, 0, 0},
         '{1, 2, 1, 'h020, 0, 0, 0},
         '{1, 3, 1, 'h020, 7, 0, 0},
         '{2, 1, 0, 5, 0, 0, 0},
         '{0, 1, 1, 4, 0, 0, 0},
         '{2, 1, 'h701, 'h702, 0, 0, 0}
      };
      string nm;
      for (int v = 0; v < 8; v++) begin
         nm = $sformatf("vec%0d", v);
         model(tv[v][0], tv[v][1], tv[v][2], tv[v][3], tv[v][4], tv[v][5], tv[v][6]);
         run_search(tv[v][0], tv[v][1], tv[v][2], tv[v][3], tv[v][4], tv[v][5], tv[v][6], 0);
         checks++;
         if (obs_timeout) begin errors++; $display("FAIL %s_timeout: no done, required done at T+%0d", nm, exp_done); end
         checks++;
         if (obs_done !== exp_done) begin errors++; $display("FAIL %s_done_cycle: got T+%0d, required T+%0d", nm, obs_done, exp_done); end
         checks++;
         if (obs_fail !== exp_fail) begin errors++; $display("FAIL %s_fail: got %0d, required %0d", nm, obs_fail, exp_fail); end
         checks++;
         if (obs_cnt !== exp_cnt) begin errors++; $display("FAIL %s_err_cnt: got %0d, required %0d", nm, obs_cnt, exp_cnt); end
         checks++;
         if (obs_pos.size() != exp_pos.size()) begin errors++; $display("FAIL %s_root_count: got %0d pulses, required %0d", nm, obs_pos.size(), exp_pos.size()); end
         for (int j = 0; j < obs_pos.size() && j < exp_pos.size(); j++) begin
            checks++;
            if (obs_pos[j] !== exp_pos[j] || obs_off[j] !== exp_off[j])
               begin errors++; $display("FAIL %s_root%0d: got pos %0d at T+%0d, required pos %0d at T+%0d", nm, j, obs_pos[j], obs_off[j], exp_pos[j], exp_off[j]); end
         end
         @(negedge clk);
         checks++;
         if (bus.done !== 1'b0 || bus.busy !== 1'b0 || int'(bus.fail) !== exp_fail || int'(bus.err_cnt) !== exp_cnt) begin
            errors++;
            $display("FAIL %s_hold: done=%b busy=%b fail=%b cnt=%0d, required done=0 busy=0 fail=%0d cnt=%0d",
                     nm, bus.done, bus.busy, bus.fail, bus.err_cnt, exp_fail, exp_cnt);
         end
      end
   endtask

   task automatic test_ignored_start();
      model(3, 2, 1, 1, 0, 0, 0);
      run_search(3, 2, 1, 1, 0, 0, 0, 300);
      checks++;
      if (obs_done !== exp_done || obs_fail !== exp_fail || obs_cnt !== exp_cnt) begin
         errors++;
         $display("FAIL ignored_start: done T+%0d fail=%0d cnt=%0d, required T+%0d fail=%0d cnt=%0d",
                  obs_done, obs_fail, obs_cnt, exp_done, exp_fail, exp_cnt);
      end
      checks++;
      if (obs_pos.size() != exp_pos.size()) begin errors++; $display("FAIL ignored_start_roots: got %0d, required %0d", obs_pos.size(), exp_pos.size()); end
   endtask

   task automatic test_back_to_back();
      run_search(1, 3, 1, 0, 0, 0, 0, 0);
      model(2, 2, 1, 'h08F, 'h08E, 0, 0);
      run_search(2, 2, 1, 'h08F, 'h08E, 0, 0, 0);
      checks++;
      if (obs_timeout || obs_done !== exp_done || obs_fail !== exp_fail || obs_cnt !== exp_cnt) begin
         errors++;
         $display("FAIL back_to_back: done T+%0d fail=%0d cnt=%0d, required T+%0d fail=%0d cnt=%0d",
                  obs_done, obs_fail, obs_cnt, exp_done, exp_fail, exp_cnt);
      end
   endtask

   task automatic test_random();
      int unsigned c, ce, d, nr, e, x;
      int unsigned p[5];
      string nm;
      for (int r = 0; r < 12; r++) begin
         nm = $sformatf("rand%0d", r);
         c = $urandom_range(0, 3);
         ce = eff(c);
         if ($urandom_range(0, 2) != 0) begin
            nr = $urandom_range(1, f_t(ce));
            p = '{1, 0, 0, 0, 0};
            for (int unsigned j = 0; j < nr; j++) begin
               e = $urandom_range(0, f_n(ce) - 1);
               x = gf_pow(e, ce);
               for (int k = 4; k >= 1; k--) p[k] = p[k] ^ gf_mul(x, p[k-1], ce);
            end
            for (int k = 0; k < 5; k++) p[k] = p[k] | ($urandom_range(0, 1) << 10);
            d = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : nr;
         end else begin
            d = $urandom_range(0, 7);
            for (int k = 0; k < 5; k++) p[k] = $urandom_range(0, 2047);
         end
         model(c, d, p[0], p[1], p[2], p[3], p[4]);
         run_search(c, d, p[0], p[1], p[2], p[3], p[4], 0);
         checks++;
         if (obs_done !== exp_done || obs_timeout) begin errors++; $display("FAIL %s_done_cycle: got T+%0d, required T+%0d", nm, obs_done, exp_done); end
         checks++;
         if (obs_fail !== exp_fail || obs_cnt !== exp_cnt) begin errors++; $display("FAIL %s_result: fail=%0d cnt=%0d, required fail=%0d cnt=%0d", nm, obs_fail, obs_cnt, exp_fail, exp_cnt); end
         checks++;
         if (obs_pos.size() != exp_pos.size()) begin errors++; $display("FAIL %s_root_count: got %0d, required %0d", nm, obs_pos.size(), exp_pos.size()); end
         for (int j = 0; j < obs_pos.size() && j < exp_pos.size(); j++) begin
            checks++;
            if (obs_pos[j] !== exp_pos[j] || obs_off[j] !== exp_off[j])
               begin errors++; $display("FAIL %s_root%0d: got pos %0d at T+%0d, required pos %0d at T+%0d", nm, j, obs_pos[j], obs_off[j], exp_pos[j], exp_off[j]); end
         end
      end
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      bus.code = 2'd3; bus.deg = 3'd2;
      bus.lambda0 = 11'd1; bus.lambda1 = 11'd1; bus.lambda2 = 11'd0; bus.lambda3 = 11'd0; bus.lambda4 = 11'd0;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (99) @(negedge clk);
      checks++;
      if (bus.busy !== 1'b1) begin errors++; $display("FAIL mid_busy: busy=%b at T+100, required 1", bus.busy); end
      rstn = 1'b0;
      #1;
      checks++;
      if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0 || bus.out_pos !== 10'd0 ||
          bus.done !== 1'b0 || bus.fail !== 1'b0 || bus.err_cnt !== 3'd0) begin
         errors++;
         $display("FAIL mid_reset_outputs: busy=%b ov=%b pos=%0d done=%b fail=%b cnt=%0d, required all 0",
                  bus.busy, bus.out_valid, bus.out_pos, bus.done, bus.fail, bus.err_cnt);
      end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL mid_reset_hold: done=%b busy=%b, required 0 0", bus.done, bus.busy); end
      end
      rstn = 1'b1;
      model(1, 1, 1, 'h020, 0, 0, 0);
      run_search(1, 1, 1, 'h020, 0, 0, 0, 0);
      checks++;
      if (obs_timeout || obs_done !== exp_done || obs_fail !== exp_fail || obs_cnt !== exp_cnt) begin
         errors++;
         $display("FAIL post_reset_search: done T+%0d fail=%0d cnt=%0d, required T+%0d fail=%0d cnt=%0d",
                  obs_done, obs_fail, obs_cnt, exp_done, exp_fail, exp_cnt);
      end
   endtask

   initial begin
      bus.start = 1'b0; bus.code = 2'd0; bus.deg = 3'd0;
      bus.lambda0 = '0; bus.lambda1 = '0; bus.lambda2 = '0; bus.lambda3 = '0; bus.lambda4 = '0;
      repeat (3) @(negedge clk);
      test_reset();
      rstn = 1'b1;
      @(negedge clk);
      test_reset();
      test_vectors();
      test_ignored_start();
      test_back_to_back();
      test_random();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
